regfile_writeback: RTL

Write-side front end for the 16x24 CPU register file. It merges two result sources, the single-cycle ALU path and the memory-load return path, into the register file's single write port (we/dst/data). Load returns are buffered in a small FIFO. ALU results always take the port. The block tracks pending load destinations for hazard checks and squashes stale loads that a newer ALU write has overtaken.

---
 rtl/regfile_writeback_if.sv | 26 ++
 rtl/regfile_writeback.sv | 121 ++++++++++++
 2 files changed

// File: rtl/regfile_writeback_if.sv
// Result-source bundle for the register-file write front end.
// ALU result lane plus the load-return lane with its ready handshake.
interface regfile_writeback_if #(
  parameter int DW = 24,
  parameter int AW = 4
);
  logic          alu_valid;
  logic [AW-1:0] alu_dst;
  logic [DW-1:0] alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_dst;
  logic [DW-1:0] mem_data;

  modport master (
    output alu_valid, alu_dst, alu_data,
    output mem_valid, mem_dst, mem_data,
    input  mem_ready
  );

  modport slave (
    input  alu_valid, alu_dst, alu_data,
    input  mem_valid, mem_dst, mem_data,
    output mem_ready
  );
endinterface

// File: rtl/regfile_writeback.sv
// Merges ALU results and buffered load returns onto the register file
// write port, squashing loads that a newer ALU write has overtaken.
module regfile_writeback #(
  parameter int DW    = 24,
  parameter int AW    = 4,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = PW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  regfile_writeback_if.slave bus,
  output logic               wb_we,
  output logic [AW-1:0]      wb_dst,
  output logic [DW-1:0]      wb_data,
  output logic [(1<<AW)-1:0] pend_mask,
  output logic [CW-1:0]      fifo_count
);

  logic [AW-1:0]    dst_q  [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] kill_q;
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic          wb_we_q, wb_we_d;
  logic [AW-1:0] wb_dst_q, wb_dst_d;
  logic [DW-1:0] wb_data_q, wb_data_d;

  logic             push, pop;
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] kill_set;

  assign bus.mem_ready = rst_n && (cnt_q < CW'(DEPTH));
  assign push = bus.mem_valid && bus.mem_ready;
  assign pop  = !bus.alu_valid && (cnt_q != '0);

  assign wb_we      = wb_we_q;
  assign wb_dst     = wb_dst_q;
  assign wb_data    = wb_data_q;
  assign fifo_count = cnt_q;

  // Occupied slots and which of them an ALU write overtakes.
  always_comb begin
    vld      = '0;
    kill_set = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] off;
      off    = PW'(i) - rd_q;
      vld[i] = CW'(off) < cnt_q;
      kill_set[i] = vld[i] && bus.alu_valid
                  && (dst_q[i] == bus.alu_dst);
    end
  end

  // Destinations still owed a write by a live load.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && !kill_q[i]) pend_mask[dst_q[i]] = 1'b1;
    end
  end

  // Write-port arbitration: ALU first, else drain the FIFO head.
  always_comb begin
    wb_we_d   = 1'b0;
    wb_dst_d  = wb_dst_q;
    wb_data_d = wb_data_q;
    unique case (1'b1)
      bus.alu_valid: begin
        wb_we_d   = 1'b1;
        wb_dst_d  = bus.alu_dst;
        wb_data_d = bus.alu_data;
      end
      pop: begin
        if (!kill_q[rd_q]) begin
          wb_we_d   = 1'b1;
          wb_dst_d  = dst_q[rd_q];
          wb_data_d = data_q[rd_q];
        end
      end
      default: ;
    endcase
  end

  // Occupancy follows push/pop; both together leave it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CW'(1);
    if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  // FIFO storage, kill marking and registered write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q      <= '0;
      wr_q      <= '0;
      cnt_q     <= '0;
      kill_q    <= '0;
      wb_we_q   <= 1'b0;
      wb_dst_q  <= '0;
      wb_data_q <= '0;
    end else begin
      wb_we_q   <= wb_we_d;
      wb_dst_q  <= wb_dst_d;
      wb_data_q <= wb_data_d;
      cnt_q     <= cnt_d;
      if (pop)  rd_q <= rd_q + PW'(1);
      if (push) wr_q <= wr_q + PW'(1);
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_set[i]) kill_q[i] <= 1'b1;
      end
      if (push) begin
        dst_q[wr_q]  <= bus.mem_dst;
        data_q[wr_q] <= bus.mem_data;
        kill_q[wr_q] <= 1'b0;
      end
    end
  end

endmodule
